// File: rtl/demux1to4_stream.sv
// -----------------------------------------------------------------------------
// demux1to4_stream
//   Registered 1-to-4 stream demultiplexer with a valid/ready handshake on every
//   port. Each accepted input word is steered by in_sel into a one-entry holding
//   register for its channel. The word stays there until that channel's consumer
//   takes it.
//
//   Ports
//     clk                  clock; all state updates on the rising edge
//     rst_n                asynchronous, active-low reset
//     in_valid / in_ready  producer handshake
//                          in_ready is combinational and does not depend on in_valid
//     in_data, in_sel      input word and destination channel (0..3)
//     in_bcast             (only with DEMUX_BROADCAST_EN) load all four channels
//     out_valid[k]         channel k holding register is full
//     out_ready[k]         consumer k takes the word this cycle
//     out_data0..3         per-channel held word
//     acc_cnt              count of accepted input transfers, wraps modulo 2^CNT_W
//
//   Build option
//     DEMUX_BROADCAST_EN   when defined, adds in_bcast and broadcast loading
// -----------------------------------------------------------------------------
module demux1to4_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
`ifdef DEMUX_BROADCAST_EN
    input  logic              in_bcast,
`endif
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [CNT_W-1:0]  acc_cnt
);

    // Per-channel EMPTY/FULL state is the valid bit itself.
    logic [3:0]        valid_q, valid_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0] chan_free;   // channel can take a word this cycle
    logic [3:0] load_mask;   // channels addressed by the current input word
    logic [3:0] load;        // channels actually loaded this cycle
    logic       bcast;
    logic       accept;

`ifdef DEMUX_BROADCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A full channel is still free if its consumer drains it in the same
    // cycle. This passes ready straight through and gives 1 word/cycle per channel.
    assign chan_free = ~valid_q | out_ready;

    always_comb begin
        load_mask         = 4'b0000;
        load_mask[in_sel] = 1'b1;
        in_ready          = chan_free[in_sel];
        if (bcast) begin
            // A broadcast needs every channel free. in_sel is ignored.
            load_mask = 4'b1111;
            in_ready  = &chan_free;
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = load_mask & {4{accept}};
    assign cnt_d  = cnt_q + CNT_W'(accept);

    // Next-state logic for each channel.
    // A load wins over a drain, so the new word replaces the old one.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign valid_d[gi] = load[gi] | (valid_q[gi] & ~out_ready[gi]);
            assign data_d[gi]  = load[gi] ? in_data : data_q[gi];
        end
    endgenerate

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Outputs
    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1to4_stream
//   Scoreboard bench for demux1to4_stream.
//   The stimulus side pushes each accepted word into the queue of its channel.
//   A negedge monitor pops and compares whenever a channel hands a word out.
//   A second instance with a 4-bit counter runs from the same inputs, so its
//   counter wraps frequently.
// -----------------------------------------------------------------------------
module tb_demux1to4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_sel;
`ifdef DEMUX_BROADCAST_EN
    logic       in_bcast;
`endif
    logic [3:0] out_ready;

    logic        in_ready;
    logic [3:0]  out_valid;
    logic [7:0]  out_data0, out_data1, out_data2, out_data3;
    logic [15:0] acc_cnt;

    logic        in_ready_s;
    logic [3:0]  out_valid_s;
    logic [7:0]  out_data0_s, out_data1_s, out_data2_s, out_data3_s;
    logic [3:0]  acc_cnt_s;

    logic [7:0] out_data_a [4];
    assign out_data_a[0] = out_data0;
    assign out_data_a[1] = out_data1;
    assign out_data_a[2] = out_data2;
    assign out_data_a[3] = out_data3;

    always #5 clk = ~clk;

    demux1to4_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast(in_bcast),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .acc_cnt(acc_cnt)
    );

    demux1to4_stream #(.DATA_W(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast(in_bcast),
`endif
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data0(out_data0_s), .out_data1(out_data1_s),
        .out_data2(out_data2_s), .out_data3(out_data3_s),
        .acc_cnt(acc_cnt_s)
    );

    // Reference model
    logic [7:0]  exp_q [4][$];    // words waiting in each channel
    logic [7:0]  last_data [4];   // value a drained channel keeps showing
    logic [15:0] model_cnt;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_data[k] = 8'h00;
        end
        model_cnt = 16'd0;
    endtask

    // A channel can take a word when it is empty or is being drained now.
    function automatic bit model_ready();
        bit r;
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) begin
            r = 1'b1;
            for (int k = 0; k < 4; k++)
                r = r & ((exp_q[k].size() == 0) || out_ready[k]);
            return r;
        end
`endif
        r = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
        return r;
    endfunction

    // Call with inputs already driven after a posedge.
    // Checks in_ready at the negedge and books the transfer at the next posedge.
    task automatic cycle(output bit acc);
        bit exp_rdy;
        bit [3:0] m;
        @(negedge clk);
        exp_rdy = model_ready();
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready_small", in_ready_s, exp_rdy);
        acc = in_valid && exp_rdy;
        @(posedge clk);
        if (acc) begin
            m = 4'b0001 << in_sel;
`ifdef DEMUX_BROADCAST_EN
            if (in_bcast) m = 4'b1111;
`endif
            for (int k = 0; k < 4; k++)
                if (m[k]) exp_q[k].push_back(in_data);
            model_cnt = model_cnt + 16'd1;
            $display("xfer %0d: mask=%b data=%02h", model_cnt, m, in_data);
        end
        #1;
    endtask

    // Monitor: compare each channel against its queue and pop on drain.
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                ev = (exp_q[k].size() != 0);
                chk($sformatf("out_valid[%0d]", k), out_valid[k], ev);
                chk($sformatf("out_valid_small[%0d]", k), out_valid_s[k], ev);
                if (ev) begin
                    chk($sformatf("out_data%0d", k), out_data_a[k], exp_q[k][0]);
                    if (out_ready[k]) last_data[k] = exp_q[k].pop_front();
                end else begin
                    chk($sformatf("hold_data%0d", k), out_data_a[k], last_data[k]);
                end
            end
            chk("acc_cnt", acc_cnt, model_cnt);
            chk("acc_cnt_small", acc_cnt_s, model_cnt[3:0]);
        end
    end

    initial begin
        bit acc;
        bit pending;
        model_clear();
        rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'b0000;
`ifdef DEMUX_BROADCAST_EN
        in_bcast = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_acc_cnt", acc_cnt, 16'h0000);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Unicast to channel 1, then a second word blocked behind it
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h3C; out_ready = 4'b0000;
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk("t2_out_valid", out_valid, 4'b0010);
        chk("t2_out_data1", out_data1, 8'h3C);
        chk("t2_acc_cnt", acc_cnt, 16'd1);
        in_valid = 1'b1; in_data = 8'h11;
        #1 chk("t2_blocked", in_ready, 1'b0);
        cycle(acc);
        out_ready = 4'b0010;           // drain and load in the same cycle
        cycle(acc);
        in_valid = 1'b0; out_ready = 4'b1111;
        cycle(acc); cycle(acc);

        // Channel 0 stalled must not block channel 2
        out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h44;
        cycle(acc);
        in_sel = 2'd2; in_data = 8'h77;
        #1 chk("t4_in_ready", in_ready, 1'b1);
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk("t4_out_valid", out_valid, 4'b0101);
        chk("t4_out_data0", out_data0, 8'h44);
        chk("t4_out_data2", out_data2, 8'h77);

        // Put 0xA5 in channel 2, then reset between edges
        out_ready = 4'b0100; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
        cycle(acc);
        out_ready = 4'b0000; in_valid = 1'b0;
        cycle(acc);
        chk("t1_pre_data2", out_data2, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_out_valid", out_valid, 4'b0000);
        chk("t1_out_data2", out_data2, 8'h00);
        chk("t1_out_data0", out_data0, 8'h00);
        chk("t1_acc_cnt", acc_cnt, 16'h0000);
        chk("t1_in_ready", in_ready, 1'b1);
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;

        // Back-to-back streaming into channel 3
        out_ready = 4'b1000;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 8'(i);
            #1 chk("t3_in_ready", in_ready, 1'b1);
            cycle(acc);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("t3_acc_cnt", acc_cnt, 16'd16);
        chk("t3_out_data3", out_data3, 8'h10);
        chk("t3_out_valid", out_valid, 4'b0000);
        chk("t5_small_wrap", acc_cnt_s, 4'h0);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast waits for the stalled channel 1
        out_ready = 4'b0000; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h21;
        cycle(acc);
        in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
        #1 chk("t6_blocked", in_ready, 1'b0);
        cycle(acc);
        out_ready = 4'b0010;
        #1 chk("t6_released", in_ready, 1'b1);
        cycle(acc);
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        cycle(acc);
        chk("t6_out_valid", out_valid, 4'b1111);
        chk("t6_out_data0", out_data0, 8'h5A);
        chk("t6_out_data1", out_data1, 8'h5A);
        chk("t6_out_data2", out_data2, 8'h5A);
        chk("t6_out_data3", out_data3, 8'h5A);
        chk("t6_acc_cnt", acc_cnt, 16'd18);
`endif

        // Random traffic; a word that is not accepted is held unchanged
        pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pending) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = 8'($urandom);
                in_sel   = 2'($urandom);
`ifdef DEMUX_BROADCAST_EN
                in_bcast = ($urandom_range(7) == 0);
`endif
            end
            out_ready = 4'($urandom);
            cycle(acc);
            pending = in_valid && !acc;
        end
        in_valid = 1'b0; out_ready = 4'b1111;
        cycle(acc); cycle(acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
